simon_req_master: RTL and testbench

SIMON_REQ_MASTER -- requirements
Module: simon_req_master

---
 rtl/simon_const_pkg.sv | 10 +
 rtl/simon_rsp_fifo.sv | 58 +++++
 rtl/simon_req_master.sv | 159 +++++++++++++++
 tb/tb_simon_req_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_const_pkg.sv
// Shared constants for the Simon request master and the Simon engine.
// Latency: none, constants only.
// Backpressure: none, constants only.
package simon_const_pkg;

    // Engine direction encoding, shared by job, engine and response mode fields.
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/simon_rsp_fifo.sv
// Two-entry first-in first-out buffer holding completed responses.
// Latency: a push is visible on pop_dat/!empty the cycle after the push edge.
// Backpressure: full blocks further pushes; pop and push in one cycle keep the count.
//
// Ports: clk/arst_n; push + push_dat in; pop in, pop_dat out (head entry);
//        full/empty status.
module simon_rsp_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          do_push;
    logic          do_pop;

    // Guard both ends so a misbehaving caller cannot corrupt the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/simon_req_master.sv
// Issues one Simon job at a time to the engine and queues the tagged result.
// Latency: job accept -> engine request next cycle; result push -> rsp_valid_o next cycle.
// Backpressure: job_ready_o only when idle; eng_ready_o drops while the response FIFO is full.
//
// Ports: job_* (valid/ready job intake), eng_* request side (valid_o/ready_i,
//        mode/blk/key out), eng_* result side (valid_i/ready_o, mode/blk in),
//        rsp_* (valid/ready response with tag, block, mode, err, latency), busy_o.
module simon_req_master
    import simon_const_pkg::*;
#(
    parameter int WW    = 16,
    parameter int NKW   = 4,
    parameter int TAG_W = 4,
    parameter int LAT_W = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    // job intake
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic                job_mode_i,
    input  logic [TAG_W-1:0]    job_tag_i,
    input  logic [2*WW-1:0]     job_blk_i,
    input  logic [NKW*WW-1:0]   job_key_i,
    // engine request
    output logic                eng_valid_o,
    input  logic                eng_ready_i,
    output logic                eng_mode_o,
    output logic [2*WW-1:0]     eng_blk_o,
    output logic [NKW*WW-1:0]   eng_key_o,
    // engine result
    input  logic                eng_valid_i,
    output logic                eng_ready_o,
    input  logic                eng_mode_i,
    input  logic [2*WW-1:0]     eng_blk_i,
    // response
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [TAG_W-1:0]    rsp_tag_o,
    output logic [2*WW-1:0]     rsp_blk_o,
    output logic                rsp_mode_o,
    output logic                rsp_err_o,
    output logic [LAT_W-1:0]    rsp_lat_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2*WW-1:0]  blk;
        logic             mode;
        logic             err;
        logic [LAT_W-1:0] lat;
    } rsp_t;

    state_t              state_q, state_d;
    logic                mode_q;
    logic [TAG_W-1:0]    tag_q;
    logic [2*WW-1:0]     blk_q;
    logic [NKW*WW-1:0]   key_q;
    logic [LAT_W-1:0]    lat_q;
    logic                job_acc;
    logic                rsp_push;
    logic                fifo_full;
    logic                fifo_empty;
    rsp_t                rsp_in;
    rsp_t                rsp_out;

    assign job_acc  = job_valid_i && job_ready_o;
    assign rsp_push = eng_valid_i && eng_ready_o;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (job_valid_i) state_d = S_REQ;
            S_REQ:   if (eng_ready_i) state_d = S_WAIT;
            S_WAIT:  if (rsp_push)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job registers drive the engine directly and are held until the next
    // accept: the engine re-reads the key during its decryption second pass.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_q <= MODE_ENC;
            tag_q  <= '0;
            blk_q  <= '0;
            key_q  <= '0;
        end else if (job_acc) begin
            mode_q <= job_mode_i;
            tag_q  <= job_tag_i;
            blk_q  <= job_blk_i;
            key_q  <= job_key_i;
        end
    end

    // Cycles in flight, saturating so very slow results read as all-ones.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lat_q <= '0;
        end else if (job_acc) begin
            lat_q <= '0;
        end else if (state_q != S_IDLE && lat_q != {LAT_W{1'b1}}) begin
            lat_q <= lat_q + LAT_W'(1);
        end
    end

    assign job_ready_o = (state_q == S_IDLE);
    assign eng_valid_o = (state_q == S_REQ);
    assign eng_ready_o = (state_q == S_WAIT) && !fifo_full;
    assign busy_o      = (state_q != S_IDLE);
    assign eng_mode_o  = mode_q;
    assign eng_blk_o   = blk_q;
    assign eng_key_o   = key_q;

    always_comb begin
        rsp_in      = '0;
        rsp_in.tag  = tag_q;
        rsp_in.blk  = eng_blk_i;
        rsp_in.mode = eng_mode_i;
        rsp_in.err  = (eng_mode_i != mode_q);
        rsp_in.lat  = lat_q;
    end

    simon_rsp_fifo #(
        .DW($bits(rsp_t))
    ) u_rsp_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .push     (rsp_push),
        .push_dat (rsp_in),
        .pop      (rsp_ready_i),
        .pop_dat  (rsp_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rsp_valid_o = !fifo_empty;
    assign rsp_tag_o   = rsp_out.tag;
    assign rsp_blk_o   = rsp_out.blk;
    assign rsp_mode_o  = rsp_out.mode;
    assign rsp_err_o   = rsp_out.err;
    assign rsp_lat_o   = rsp_out.lat;

endmodule

// File: tb/tb_simon_req_master.sv
// Testbench for simon_req_master with a behavioural Simon32/64 engine.
// Latency: n/a.
// Backpressure: engine and response-side stalls are driven from the bench.
module tb_simon_req_master;

    logic        clk;
    logic        arst_n;
    logic        job_valid_i, job_ready_o, job_mode_i;
    logic [3:0]  job_tag_i;
    logic [31:0] job_blk_i;
    logic [63:0] job_key_i;
    logic        eng_valid_o, eng_ready_i, eng_mode_o;
    logic [31:0] eng_blk_o;
    logic [63:0] eng_key_o;
    logic        eng_valid_i, eng_ready_o, eng_mode_i;
    logic [31:0] eng_blk_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [3:0]  rsp_tag_o;
    logic [31:0] rsp_blk_o;
    logic        rsp_mode_o, rsp_err_o;
    logic [7:0]  rsp_lat_o;
    logic        busy_o;

    simon_req_master dut (
        .clk(clk), .arst_n(arst_n),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_mode_i(job_mode_i),
        .job_tag_i(job_tag_i), .job_blk_i(job_blk_i), .job_key_i(job_key_i),
        .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i), .eng_mode_o(eng_mode_o),
        .eng_blk_o(eng_blk_o), .eng_key_o(eng_key_o),
        .eng_valid_i(eng_valid_i), .eng_ready_o(eng_ready_o), .eng_mode_i(eng_mode_i),
        .eng_blk_i(eng_blk_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tag_o(rsp_tag_o),
        .rsp_blk_o(rsp_blk_o), .rsp_mode_o(rsp_mode_o), .rsp_err_o(rsp_err_o),
        .rsp_lat_o(rsp_lat_o), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        mode;
        logic [3:0]  tag;
        logic [31:0] blk;
        logic [63:0] key;
    } job_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] blk;
        logic        mode;
        logic        err;
        logic [7:0]  lat;
    } rsp_t;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;

    // Reference model state: jobs to offer, responses expected in order.
    job_t job_q[$];
    rsp_t exp_q[$];
    logic [3:0] tag_log[$];
    job_t cur;
    rsp_t last;
    logic m_busy = 1'b0;
    logic m_handed = 1'b0;
    int   acc_cyc = 0;

    // Engine model configuration and state.
    int   rdy_fix = 0;
    int   res_fix = 0;
    int   flip_mode = 0;
    int   rsp_mode = 1;
    logic stray_en = 1'b0;
    int   e_phase = 0;
    int   e_cnt = 0;
    logic [31:0] e_res;
    logic e_mode_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] v);
        return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
    endfunction

    // Simon32/64 straight from the cipher definition.
    function automatic logic [31:0] simon(input logic [31:0] blk, input logic [63:0] key,
                                          input logic dec);
        logic [15:0] rk [32];
        logic [0:61] z;
        logic [15:0] x, y, t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) rk[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol16(rk[i-1], 13) ^ rk[i-3];
            t = t ^ rol16(t, 15);
            rk[i] = ~rk[i-4] ^ t ^ {15'd0, z[i-4]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (!dec) begin
            for (int i = 0; i < 32; i++) begin
                t = x; x = y ^ f16(x) ^ rk[i]; y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y; y = x ^ f16(y) ^ rk[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // One clock: check DUT status against the model, drive inputs, update model.
    task automatic cycle();
        logic acc, eng_hs, res_hs, pop;
        int   d;
        rsp_t r;
        @(negedge clk);
        cyc++;
        chk("busy", busy_o, m_busy);
        chk("job_rdy", job_ready_o, !m_busy);
        chk("eng_vld", eng_valid_o, m_busy && !m_handed);
        chk("eng_rdy", eng_ready_o, m_handed && (exp_q.size() < 2));
        chk("rsp_vld", rsp_valid_o, exp_q.size() != 0);

        if (job_q.size() != 0) begin
            job_valid_i = 1'b1;
            {job_mode_i, job_tag_i, job_blk_i, job_key_i} = job_q[0];
        end else begin
            job_valid_i = 1'b0;
            job_mode_i  = 1'($urandom);
            job_tag_i   = 4'($urandom);
            job_blk_i   = $urandom;
            job_key_i   = {$urandom, $urandom};
        end
        acc = job_valid_i && job_ready_o;

        eng_ready_i = 1'b0;
        eng_valid_i = 1'b0;
        eng_blk_i   = $urandom;
        eng_mode_i  = 1'($urandom);
        eng_hs = 1'b0;
        res_hs = 1'b0;
        if (stray_en && e_phase < 2 && $urandom_range(0, 3) == 0) eng_valid_i = 1'b1;
        if (e_phase == 0 && eng_valid_o) begin
            e_phase = 1;
            e_cnt = (rdy_fix < 0) ? int'($urandom_range(0, 4)) : rdy_fix;
        end
        if (e_phase == 1) begin
            if (e_cnt == 0) begin
                eng_ready_i = 1'b1;
                eng_hs = eng_valid_o;
            end else begin
                e_cnt--;
            end
        end else if (e_phase == 2) begin
            if (e_cnt == 0) e_phase = 3;
            else e_cnt--;
        end
        if (e_phase == 3) begin
            eng_valid_i = 1'b1;
            eng_blk_i   = e_res;
            eng_mode_i  = e_mode_ret;
            res_hs      = eng_ready_o;
        end

        case (rsp_mode)
            0:       rsp_ready_i = 1'b0;
            1:       rsp_ready_i = 1'b1;
            default: rsp_ready_i = 1'($urandom_range(0, 1));
        endcase
        pop = rsp_valid_o && rsp_ready_i;

        if (eng_hs) begin
            chk("eng_mode", eng_mode_o, cur.mode);
            chk("eng_blk", eng_blk_o, cur.blk);
            chk("eng_key", eng_key_o, cur.key);
            e_res = simon(cur.blk, cur.key, cur.mode);
            e_mode_ret = cur.mode ^ ((flip_mode == 2) ? 1'($urandom) : (flip_mode == 1));
            e_phase = 2;
            e_cnt = (res_fix < 0) ? int'($urandom_range(0, 6)) : res_fix;
            m_handed = 1'b1;
        end
        if (pop) begin
            last = {rsp_tag_o, rsp_blk_o, rsp_mode_o, rsp_err_o, rsp_lat_o};
            tag_log.push_back(rsp_tag_o);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_tag", rsp_tag_o, exp_q[0].tag);
                chk("rsp_blk", rsp_blk_o, exp_q[0].blk);
                chk("rsp_mode", rsp_mode_o, exp_q[0].mode);
                chk("rsp_err", rsp_err_o, exp_q[0].err);
                chk("rsp_lat", rsp_lat_o, exp_q[0].lat);
                void'(exp_q.pop_front());
            end
        end
        if (res_hs) begin
            chk("eng_key_hold", eng_key_o, cur.key);
            chk("eng_blk_hold", eng_blk_o, cur.blk);
            d = cyc - acc_cyc - 1;
            r.tag  = cur.tag;
            r.blk  = e_res;
            r.mode = e_mode_ret;
            r.err  = (e_mode_ret != cur.mode);
            r.lat  = (d > 255) ? 8'd255 : 8'(d);
            exp_q.push_back(r);
            e_phase  = 0;
            m_busy   = 1'b0;
            m_handed = 1'b0;
        end
        if (acc) begin
            cur = job_q.pop_front();
            acc_cyc = cyc;
            m_busy = 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((job_q.size() != 0 || m_busy || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n >= budget, 0);
    endtask

    task automatic add_job(input logic mode, input logic [3:0] tag,
                           input logic [31:0] blk, input logic [63:0] key);
        job_t j;
        j.mode = mode; j.tag = tag; j.blk = blk; j.key = key;
        job_q.push_back(j);
    endtask

    initial begin
        arst_n = 1'b0;
        job_valid_i = 1'b0; job_mode_i = 1'b0; job_tag_i = '0; job_blk_i = '0; job_key_i = '0;
        eng_ready_i = 1'b0; eng_valid_i = 1'b0; eng_mode_i = 1'b0; eng_blk_i = '0;
        rsp_ready_i = 1'b0;
        #3;
        chk("rst_job_rdy", job_ready_o, 1);
        chk("rst_eng_vld", eng_valid_o, 0);
        chk("rst_eng_rdy", eng_ready_o, 0);
        chk("rst_rsp_vld", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_eng_dat", {eng_mode_o, eng_blk_o}, 0);
        chk("rst_eng_key", eng_key_o, 0);
        chk("rst_rsp_dat", {rsp_tag_o, rsp_blk_o, rsp_mode_o, rsp_err_o, rsp_lat_o}, 0);
        @(negedge clk);
        #2 arst_n = 1'b1;

        // Known-answer encryption and decryption.
        rdy_fix = 1; res_fix = 2; rsp_mode = 1;
        add_job(1'b0, 4'h5, 32'h65656877, 64'h1918111009080100);
        drain(200);
        chk("kat_enc_blk", last.blk, 32'hc69be9bb);
        chk("kat_enc_mode", last.mode, 0);
        chk("kat_enc_err", last.err, 0);
        chk("kat_enc_tag", last.tag, 4'h5);
        add_job(1'b1, 4'h6, 32'hc69be9bb, 64'h1918111009080100);
        drain(200);
        chk("kat_dec_blk", last.blk, 32'h65656877);
        chk("kat_dec_mode", last.mode, 1);
        chk("kat_dec_err", last.err, 0);

        // Latency counting and saturation.
        rdy_fix = 3; res_fix = 5;
        add_job(1'b0, 4'h7, 32'h01234567, 64'h0);
        drain(200);
        chk("lat_9", last.lat, 9);
        res_fix = 300;
        add_job(1'b1, 4'h8, 32'h89abcdef, 64'h1);
        drain(1000);
        chk("lat_sat", last.lat, 255);

        // Response backpressure with three jobs.
        rdy_fix = 1; res_fix = 1; rsp_mode = 0;
        for (int i = 1; i <= 3; i++) add_job(1'($urandom), 4'(i), $urandom, {$urandom, $urandom});
        repeat (40) cycle();
        chk("bp_busy", busy_o, 1);
        chk("bp_eng_rdy", eng_ready_o, 0);
        chk("bp_rsp_vld", rsp_valid_o, 1);
        tag_log.delete();
        rsp_mode = 1;
        drain(200);
        chk("bp_count", tag_log.size(), 3);
        for (int i = 0; i < 3 && i < tag_log.size(); i++) chk("bp_order", tag_log[i], 4'(i + 1));

        // Mode mismatch, then stray engine results while idle.
        flip_mode = 1;
        add_job(1'b0, 4'h9, 32'h11112222, 64'h3);
        drain(200);
        chk("err_flag", last.err, 1);
        chk("err_mode", last.mode, 1);
        flip_mode = 0;
        stray_en = 1'b1;
        repeat (30) cycle();
        chk("stray_no_rsp", rsp_valid_o, 0);
        stray_en = 1'b0;

        // Reset while waiting for the engine result.
        rdy_fix = 0; res_fix = 50;
        add_job(1'b0, 4'ha, 32'h33334444, 64'h5);
        repeat (10) cycle();
        #1 arst_n = 1'b0;
        #1;
        chk("mid_rst_job_rdy", job_ready_o, 1);
        chk("mid_rst_rsp_vld", rsp_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        #1 arst_n = 1'b1;
        job_valid_i = 1'b0; eng_valid_i = 1'b0;
        job_q.delete(); exp_q.delete();
        m_busy = 1'b0; m_handed = 1'b0; e_phase = 0;
        res_fix = 2;
        add_job(1'b1, 4'hb, 32'h55556666, 64'h7);
        drain(200);
        chk("post_rst_tag", last.tag, 4'hb);
        chk("post_rst_err", last.err, 0);

        // Randomised traffic.
        rdy_fix = -1; res_fix = -1; rsp_mode = 2; flip_mode = 2; stray_en = 1'b1;
        for (int i = 0; i < 150; i++) add_job(1'($urandom), 4'($urandom), $urandom, {$urandom, $urandom});
        drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
